// File: rtl/simple_cpu_pkg.sv
// Shared CPU-wide widths and the writeback queue entry type.
package simple_cpu_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 2 ** REG_ADDR_W;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;
endpackage

// File: rtl/regfile_wb_fifo.sv
// Generic in-order queue with wrap-bit pointers; also exposes its entries
// oldest-first so the owner can scan the valid window.
module regfile_wb_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 37
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level,
  output logic [DEPTH-1:0][W-1:0]    ordered
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage is not reset: the pointers alone decide which slots are live.
  always_ff @(posedge clock) begin
    if (push) mem[wptr[AW-1:0]] <= push_data;
  end

  assign level = wptr - rptr;
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign head  = (level != '0) ? mem[rptr[AW-1:0]] : '0;

  always_comb begin
    logic [AW-1:0] idx;
    idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx        = rptr[AW-1:0] + AW'(k);
      ordered[k] = mem[idx];
    end
  end
endmodule

// File: rtl/regfile_writeback.sv
// Register-file write side: queues execute results, drains one per cycle,
// and publishes pending destinations. Optional lookup: REGFILE_WB_FORWARD_EN.
module regfile_writeback
  import simple_cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  // Handshake: a result transfers on a rising edge where in_valid && in_ready;
  // in_ready depends only on registered state, never on in_valid.
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [REG_ADDR_W-1:0]   in_rd,
  input  logic [XLEN-1:0]         in_data,
`ifdef REGFILE_WB_FORWARD_EN
  input  logic [REG_ADDR_W-1:0]   fwd_rs1,
  input  logic [REG_ADDR_W-1:0]   fwd_rs2,
  output logic                    fwd_rs1_hit,
  output logic                    fwd_rs2_hit,
  output logic [XLEN-1:0]         fwd_rs1_data,
  output logic [XLEN-1:0]         fwd_rs2_data,
`endif
  input  logic                    rf_ready,
  output logic                    rf_we,
  output logic [REG_ADDR_W-1:0]   rf_waddr,
  output logic [XLEN-1:0]         rf_wdata,
  output logic [NUM_REGS-1:0]     pending_mask,
  output logic [$clog2(DEPTH):0]  level
);
  localparam int W = $bits(wb_entry_t);

  logic                   ready_en;
  logic                   full;
  logic                   push;
  wb_entry_t              push_entry;
  wb_entry_t              head_entry;
  wb_entry_t [DEPTH-1:0]  ordered;

  // Holds in_ready low through reset and for nothing longer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  assign in_ready   = ready_en && !full;
  assign push       = in_valid && in_ready && (in_rd != '0);
  assign push_entry = '{rd: in_rd, data: in_data};

  regfile_wb_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (rf_we),
    .head      (head_entry),
    .full      (full),
    .level     (level),
    .ordered   (ordered)
  );

  assign rf_we    = (level != '0) && rf_ready;
  assign rf_waddr = head_entry.rd;
  assign rf_wdata = head_entry.data;

  always_comb begin
    pending_mask = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (k < int'(level)) pending_mask[ordered[k].rd] = 1'b1;
    end
    pending_mask[0] = 1'b0;
  end

`ifdef REGFILE_WB_FORWARD_EN
  // Scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    fwd_rs1_hit  = 1'b0;
    fwd_rs2_hit  = 1'b0;
    fwd_rs1_data = '0;
    fwd_rs2_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (k < int'(level) && fwd_rs1 != '0 && ordered[k].rd == fwd_rs1) begin
        fwd_rs1_hit  = 1'b1;
        fwd_rs1_data = ordered[k].data;
      end
      if (k < int'(level) && fwd_rs2 != '0 && ordered[k].rd == fwd_rs2) begin
        fwd_rs2_hit  = 1'b1;
        fwd_rs2_data = ordered[k].data;
      end
    end
  end
`else
  logic unused_fwd_data;
  assign unused_fwd_data = ^ordered;
`endif
endmodule

// File: tb/tb_regfile_writeback.sv
// Directed vector table plus hand sequences for regfile_writeback.
module tb_regfile_writeback;
  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [31:0] in_data;
  logic        rf_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] pending_mask;
  logic [2:0]  level;
`ifdef REGFILE_WB_FORWARD_EN
  logic [4:0]  fwd_rs1, fwd_rs2;
  logic        fwd_rs1_hit, fwd_rs2_hit;
  logic [31:0] fwd_rs1_data, fwd_rs2_data;
`endif

  always #5 clock = ~clock;

  regfile_writeback #(.DEPTH(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_rd        (in_rd),
    .in_data      (in_data),
`ifdef REGFILE_WB_FORWARD_EN
    .fwd_rs1      (fwd_rs1),
    .fwd_rs2      (fwd_rs2),
    .fwd_rs1_hit  (fwd_rs1_hit),
    .fwd_rs2_hit  (fwd_rs2_hit),
    .fwd_rs1_data (fwd_rs1_data),
    .fwd_rs2_data (fwd_rs2_data),
`endif
    .rf_ready     (rf_ready),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .pending_mask (pending_mask),
    .level        (level)
  );

  typedef struct {
    logic        v;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        rdy;
    logic        e_ready;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic [31:0] e_mask;
    logic [2:0]  e_level;
  } vec_t;

  vec_t        vecs[$];
  logic [36:0] exp_q[$];
  logic [36:0] got_q[$];
  int          tests = 0;
  int          fails = 0;

  always @(posedge clock) begin
    if (reset && rf_we) got_q.push_back({rf_waddr, rf_wdata});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [4:0] rd, input logic [31:0] d, input logic rdy,
                     input logic er, input logic ew, input logic [4:0] ea, input logic [31:0] ed,
                     input logic [31:0] em, input logic [2:0] el);
    vec_t t;
    t = '{v, rd, d, rdy, er, ew, ea, ed, em, el};
    vecs.push_back(t);
  endtask

  task automatic step(input logic v, input logic [4:0] rd, input logic [31:0] d, input logic rdy);
    @(negedge clock);
    in_valid = v;
    in_rd    = rd;
    in_data  = d;
    rf_ready = rdy;
  endtask

  initial begin
    int n0;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_rd    = '0;
    in_data  = '0;
    rf_ready = 1'b1;
`ifdef REGFILE_WB_FORWARD_EN
    fwd_rs1  = '0;
    fwd_rs2  = '0;
`endif

    // Columns: valid rd data rf_ready | in_ready rf_we waddr wdata mask level (pre-edge)
    add(1'b1, 5'd5,  32'd42,  1'b1, 1'b1, 1'b0, 5'd0,  32'd0,   32'h0,      3'd0);
    add(1'b0, 5'd0,  32'd0,   1'b1, 1'b1, 1'b1, 5'd5,  32'd42,  32'h20,     3'd1);
    add(1'b0, 5'd0,  32'd0,   1'b1, 1'b1, 1'b0, 5'd0,  32'd0,   32'h0,      3'd0);
    add(1'b1, 5'd0,  32'd99,  1'b1, 1'b1, 1'b0, 5'd0,  32'd0,   32'h0,      3'd0);
    add(1'b0, 5'd0,  32'd0,   1'b1, 1'b1, 1'b0, 5'd0,  32'd0,   32'h0,      3'd0);
    add(1'b1, 5'd1,  32'd11,  1'b0, 1'b1, 1'b0, 5'd0,  32'd0,   32'h0,      3'd0);
    add(1'b1, 5'd2,  32'd12,  1'b0, 1'b1, 1'b0, 5'd1,  32'd11,  32'h2,      3'd1);
    add(1'b1, 5'd3,  32'd13,  1'b0, 1'b1, 1'b0, 5'd1,  32'd11,  32'h6,      3'd2);
    add(1'b1, 5'd4,  32'd14,  1'b0, 1'b1, 1'b0, 5'd1,  32'd11,  32'hE,      3'd3);
    add(1'b1, 5'd9,  32'd99,  1'b0, 1'b0, 1'b0, 5'd1,  32'd11,  32'h1E,     3'd4);
    add(1'b1, 5'd9,  32'd99,  1'b1, 1'b0, 1'b1, 5'd1,  32'd11,  32'h1E,     3'd4);
    add(1'b1, 5'd9,  32'd99,  1'b1, 1'b1, 1'b1, 5'd2,  32'd12,  32'h1C,     3'd3);
    add(1'b0, 5'd0,  32'd0,   1'b1, 1'b1, 1'b1, 5'd3,  32'd13,  32'h218,    3'd3);
    add(1'b0, 5'd0,  32'd0,   1'b1, 1'b1, 1'b1, 5'd4,  32'd14,  32'h210,    3'd2);
    add(1'b0, 5'd0,  32'd0,   1'b1, 1'b1, 1'b1, 5'd9,  32'd99,  32'h200,    3'd1);
    add(1'b0, 5'd0,  32'd0,   1'b1, 1'b1, 1'b0, 5'd0,  32'd0,   32'h0,      3'd0);
    add(1'b1, 5'd10, 32'd100, 1'b0, 1'b1, 1'b0, 5'd0,  32'd0,   32'h0,      3'd0);
    add(1'b1, 5'd11, 32'd101, 1'b0, 1'b1, 1'b0, 5'd10, 32'd100, 32'h400,    3'd1);
    add(1'b1, 5'd12, 32'd102, 1'b1, 1'b1, 1'b1, 5'd10, 32'd100, 32'hC00,    3'd2);
    add(1'b1, 5'd13, 32'd103, 1'b1, 1'b1, 1'b1, 5'd11, 32'd101, 32'h1800,   3'd2);
    add(1'b1, 5'd14, 32'd104, 1'b1, 1'b1, 1'b1, 5'd12, 32'd102, 32'h3000,   3'd2);
    add(1'b1, 5'd15, 32'd105, 1'b1, 1'b1, 1'b1, 5'd13, 32'd103, 32'h6000,   3'd2);
    add(1'b1, 5'd16, 32'd106, 1'b1, 1'b1, 1'b1, 5'd14, 32'd104, 32'hC000,   3'd2);
    add(1'b0, 5'd0,  32'd0,   1'b1, 1'b1, 1'b1, 5'd15, 32'd105, 32'h18000,  3'd2);
    add(1'b0, 5'd0,  32'd0,   1'b1, 1'b1, 1'b1, 5'd16, 32'd106, 32'h10000,  3'd1);
    add(1'b0, 5'd0,  32'd0,   1'b1, 1'b1, 1'b0, 5'd0,  32'd0,   32'h0,      3'd0);
    add(1'b1, 5'd7,  32'd1,   1'b0, 1'b1, 1'b0, 5'd0,  32'd0,   32'h0,      3'd0);
    add(1'b1, 5'd7,  32'd2,   1'b0, 1'b1, 1'b0, 5'd7,  32'd1,   32'h80,     3'd1);
    add(1'b0, 5'd0,  32'd0,   1'b1, 1'b1, 1'b1, 5'd7,  32'd1,   32'h80,     3'd2);
    add(1'b0, 5'd0,  32'd0,   1'b1, 1'b1, 1'b1, 5'd7,  32'd2,   32'h80,     3'd1);
    add(1'b0, 5'd0,  32'd0,   1'b1, 1'b1, 1'b0, 5'd0,  32'd0,   32'h0,      3'd0);

    #2 reset = 1'b0;
    #10;
    check("rst.in_ready", 32'(in_ready), 32'd0);
    check("rst.rf_we", 32'(rf_we), 32'd0);
    check("rst.level", 32'(level), 32'd0);
    check("rst.mask", pending_mask, 32'h0);
    @(negedge clock);
    reset = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].v, vecs[i].rd, vecs[i].data, vecs[i].rdy);
      #1;
      check($sformatf("v%0d.in_ready", i), 32'(in_ready), 32'(vecs[i].e_ready));
      check($sformatf("v%0d.rf_we", i), 32'(rf_we), 32'(vecs[i].e_we));
      check($sformatf("v%0d.waddr", i), 32'(rf_waddr), 32'(vecs[i].e_addr));
      check($sformatf("v%0d.wdata", i), rf_wdata, vecs[i].e_data);
      check($sformatf("v%0d.mask", i), pending_mask, vecs[i].e_mask);
      check($sformatf("v%0d.level", i), 32'(level), 32'(vecs[i].e_level));
      if (vecs[i].v && vecs[i].e_ready && vecs[i].rd != 5'd0)
        exp_q.push_back({vecs[i].rd, vecs[i].data});
    end

`ifdef REGFILE_WB_FORWARD_EN
    step(1'b1, 5'd7, 32'd10, 1'b0);
    exp_q.push_back({5'd7, 32'd10});
    step(1'b1, 5'd7, 32'd20, 1'b0);
    exp_q.push_back({5'd7, 32'd20});
    step(1'b0, 5'd0, 32'd0, 1'b0);
    fwd_rs1 = 5'd7;
    fwd_rs2 = 5'd0;
    #1;
    check("fwd.rs1_hit", 32'(fwd_rs1_hit), 32'd1);
    check("fwd.rs1_data", fwd_rs1_data, 32'd20);
    check("fwd.rs2_hit", 32'(fwd_rs2_hit), 32'd0);
    check("fwd.rs2_data", fwd_rs2_data, 32'd0);
    repeat (3) step(1'b0, 5'd0, 32'd0, 1'b1);
`endif

    step(1'b0, 5'd0, 32'd0, 1'b1);
    check("sb.count", 32'(got_q.size()), 32'(exp_q.size()));
    foreach (exp_q[i]) begin
      if (i < got_q.size()) begin
        check($sformatf("sb%0d.rd", i), 32'(got_q[i][36:32]), 32'(exp_q[i][36:32]));
        check($sformatf("sb%0d.data", i), got_q[i][31:0], exp_q[i][31:0]);
      end
    end

    // Asynchronous reset while three writes are waiting to drain.
    step(1'b1, 5'd1, 32'd1, 1'b0);
    step(1'b1, 5'd2, 32'd2, 1'b0);
    step(1'b1, 5'd3, 32'd3, 1'b0);
    step(1'b0, 5'd0, 32'd0, 1'b0);
    #1;
    check("ar.level_before", 32'(level), 32'd3);
    @(negedge clock);
    rf_ready = 1'b1;
    #1;
    check("ar.we_before", 32'(rf_we), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("ar.rf_we", 32'(rf_we), 32'd0);
    check("ar.level", 32'(level), 32'd0);
    check("ar.mask", pending_mask, 32'h0);
    check("ar.in_ready", 32'(in_ready), 32'd0);
    n0 = got_q.size();
    @(negedge clock);
    #2 reset = 1'b1;
    repeat (4) begin
      @(negedge clock);
      #1;
      check("ar.no_stale_we", 32'(rf_we), 32'd0);
    end
    check("ar.no_stale_log", 32'(got_q.size()), 32'(n0));
    check("ar.in_ready_back", 32'(in_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Write side of the register file: takes execute-stage results (rd, data) over a valid/ready handshake and buffers them in a small in-order queue.
- Drains one entry per cycle into the register-file write port whenever that port is ready.
- Exports a pending-destination mask so decode can stall on read-after-write hazards.
- Sits between the ALU result path and register_file.

Parameters:
- DEPTH, 4, queue entries; power of two, >= 2.
- XLEN, 32, data width.
- REG_ADDR_W, 5, register index width (32 architectural registers).

Ports:
- clock  input  1  single clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  execute result valid.
- in_ready  output  1  queue can accept.
- in_rd  input  REG_ADDR_W  destination register.
- in_data  input  XLEN  result value.
- rf_ready  input  1  register file accepts a write this cycle.
- rf_we  output  1  register-file write enable.
- rf_waddr  output  REG_ADDR_W  write address (head rd).
- rf_wdata  output  XLEN  write data (head data).
- pending_mask  output  2**REG_ADDR_W  bit r = a queued write targets register r.
- level  output  $clog2(DEPTH)+1  number of queued entries.

Behaviour:
Reset (reset low, asynchronous):
- All entries are discarded and the pointers cleared.
- rf_we=0, level=0, pending_mask=0.
- in_ready=0 while reset is low; it returns to 1 on the first cycle after release.
- Reset while the queue is draining drops the remaining writes; rf_we falls with reset, not at the next edge.

Accept:
- An entry is accepted on a rising edge with in_valid && in_ready.
- in_ready = (level < DEPTH). It depends only on registered state, never on in_valid.

x0 handling:
- An accepted entry with in_rd=0 is consumed and discarded.
- It is not queued: level and pending_mask are unchanged and rf_we never fires for it.

Latency:
- No fall-through. An entry accepted at edge N is at the head from edge N onward, so rf_we can assert in the cycle after acceptance at the earliest.

Drain:
- rf_we = (level != 0) && rf_ready, combinational.
- rf_waddr and rf_wdata always show the head entry; both are 0 when empty.
- On an edge with rf_we=1, the head is popped.
- Strict FIFO order, one write per cycle.

Simultaneous push and pop:
- Allowed when 0 < level < DEPTH; level stays the same.
- Empty: a push cannot pop in the same cycle (no bypass).
- Full: in_ready=0, so only a pop occurs. in_ready rises the following cycle.

Pointers:
- Read and write pointers are $clog2(DEPTH)+1 bits wide and wrap naturally.
- level = wptr - rptr.
- Full: MSBs differ and the low bits are equal.

pending_mask:
- OR of the one-hot decodes of rd over valid entries, registered-state based.
- Bit 0 is always 0.
- Duplicate rd entries keep the bit set until the last one drains.

Optional Feature:
- Macro: REGFILE_WB_FORWARD_EN.
- When defined, adds these ports:
  - fwd_rs1, fwd_rs2 (input, REG_ADDR_W)
  - fwd_rs1_hit, fwd_rs2_hit (output, 1)
  - fwd_rs1_data, fwd_rs2_data (output, XLEN)
- Each lookup combinationally returns the data of the youngest queued entry whose rd matches.
- hit=0 and data=0 when there is no match or the lookup address is 0.
- Undefined: these ports and the match logic are absent; all other behaviour is identical.

Decomposition:
- Package simple_cpu_pkg holds:
  - XLEN, REG_ADDR_W, NUM_REGS localparams.
  - typedef wb_entry_t, a packed struct {rd, data}.
- Sub-module regfile_wb_fifo:
  - Generic DEPTH-entry wb_entry_t FIFO with pointers and level.
  - Instantiated once.
- The top level adds x0 filtering, the rf_* mapping, pending_mask, and the optional forwarding.

Test Plan:
- Reset then single write: release reset; push rd=5, data=42 with rf_ready=1.
  - Next cycle: rf_we=1, rf_waddr=5, rf_wdata=42, pending_mask=0x20, level=1.
  - Cycle after: rf_we=0, pending_mask=0, level=0.
- x0 discard: push rd=0, data=99.
  - in_ready=1 throughout, level stays 0, rf_we never asserts.
- Backpressure and full: rf_ready=0; push rd=1..4 with data 11..14, then hold rd=9 valid.
  - level=4, in_ready=0, pending_mask=0x1E; rd=9 not accepted.
  - Set rf_ready=1: writes 1,2,3,4 with data 11,12,13,14 on consecutive cycles.
  - rd=9 is accepted on the edge after the first pop.
- Simultaneous push/pop: at level=2 with rf_ready=1, push each cycle for 5 cycles.
  - level stays 2 and writes come out in push order.
- Async reset mid-drain: with level=3, drive reset low between edges.
  - rf_we=0, level=0, pending_mask=0 immediately.
  - After release, no stale writes appear.
- Forwarding (REGFILE_WB_FORWARD_EN): rf_ready=0; queue rd=7 data=10, then rd=7 data=20.
  - fwd_rs1=7 gives hit=1, data=20.
  - fwd_rs2=0 gives hit=0, data=0.
